arbitro_botones: RTL
====================

# arbitro_botones

Button front-end controller for the panel push-buttons. It debounces N_BTN raw button inputs on a slow sample tick and turns presses, plus auto-repeat while a button is held, into discrete events. It then arbitrates those events round-robin onto a single valid/ready event port. The event port feeds the configuration/state FSM that consumes button commands, so that FSM never sees bounce, simultaneous presses or lost presses.

## Interface
- SAMPLE_DIV, 1000: clk cycles per debounce sample tick (≥2)
- DB_LEN, 4: consecutive equal samples required to change a debounced level (2..8)
- HOLD_TICKS, 500: ticks a button must stay high before first auto-repeat
- REPEAT_TICKS, 100: ticks between subsequent auto-repeats
- N_BTN, 4: number of buttons (fixed 4 in this revision; ID_W = 2)

- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- btn_in  in  4  raw button inputs, active-high, asynchronous to clk
- evt_ready  in  1  consumer accepts the offered event
- evt_valid  out  1  event offered
- evt_id  out  2  index of button producing the event
- evt_repeat  out  1  0 = fresh press, 1 = auto-repeat
- btn_level  out  4  debounced button levels

## Operation
- btn_in goes through a 2-flop synchronizer before any use.
- Tick generator counts 0..SAMPLE_DIV-1, wraps; tick = 1 for one cycle when count == SAMPLE_DIV-1.
- Per button, on each tick: shift synchronized sample into a DB_LEN-bit history. btn_level[i] goes to 1 when the history is all ones and to 0 when it is all zeros. Otherwise it holds (hysteresis).
- Press: btn_level[i] 0→1 sets pend[i] = 1, rep[i] = 0. Hold counter[i] clears.
- Hold: while btn_level[i] = 1, hold counter increments on each tick. Reaching HOLD_TICKS sets pend[i] = 1, rep[i] = 1 and reloads the counter to HOLD_TICKS-REPEAT_TICKS, so the next repeat comes REPEAT_TICKS later. On release the counter clears.
- Pending is one bit per button. A new event on an already-pending button coalesces, and rep[i] takes the newest setter.
- Arbiter FSM, two states:
  - IDLE: if pend != 0, pick the first set bit at or after ptr (modulo 4). Latch evt_id and evt_repeat, clear that pend bit, go to OFFER.
  - OFFER: evt_valid = 1. evt_id and evt_repeat are held stable. On evt_ready = 1: ptr = evt_id+1 (mod 4), go to IDLE. Otherwise stay.
- Same-cycle set and clear of a pend bit: set wins, so the event stays pending for a later grant.
- evt_ready while in IDLE is ignored.
- Reset (any time, including mid-OFFER) clears all state asynchronously.

## Timing
- Reset values: evt_valid = 0, evt_id = 0, evt_repeat = 0, btn_level = 0, pend = 0, rep = 0, ptr = 0, state = IDLE, tick counter = 0, histories = 0, hold counters = 0.
- btn_in to synchronized sample: 2 cycles.
- btn_level rises on the clock edge of the DB_LEN-th consecutive high tick.
- pend sets 1 cycle after btn_level rises.
- evt_valid rises 1 cycle after pend sets (IDLE→OFFER).
- Throughput: at most one event per 2 cycles (OFFER, then IDLE).
- Handshake: transfer when evt_valid & evt_ready at a rising edge. evt_valid deasserts the following cycle.
- Releasing a button never retracts an already-pending or already-offered event.

## Test plan
Bench parameters: SAMPLE_DIV = 4, DB_LEN = 4, HOLD_TICKS = 8, REPEAT_TICKS = 4, evt_ready tied 1 unless stated.
- Clean press: btn_in[2] = 1 held for 20 ticks, then 0 → exactly one event with evt_id = 2, evt_repeat = 0. btn_level[2] = 1 within (4 ticks × 4 + 2 sync) cycles and later returns to 0.
- Bounce: btn_in[0] toggles every 5 cycles for 60 cycles, then settles at 1 → no event during toggling. Exactly one event with evt_id = 0 after settling.
- Auto-repeat: btn_in[1] held for 20 ticks → press event (repeat = 0), then repeat events (repeat = 1) at hold ticks 8, 12, 16, 20. Total 5 events.
- Simultaneous presses: btn_in = 4'b1111 in one cycle, ptr = 0 → ids 0, 1, 2, 3 in order, spaced 2 cycles apart. A second identical burst yields 0, 1, 2, 3 again (ptr back at 0).
- Backpressure: evt_ready = 0 for 50 cycles with a press on button 3 → evt_valid stays 1 with evt_id = 3 stable throughout. Raising evt_ready gives exactly one transfer.
- Reset mid-offer: rst_n = 0 while evt_valid = 1 → evt_valid, btn_level and pend = 0 immediately, with no clock needed. After release, with buttons low, no event appears.

Source files
------------

// File: rtl/arbitro_botones.sv
// rtl/arbitro_botones.sv - debounced push-button front end with auto-repeat and round-robin event port
module arbitro_botones #(
    parameter int SAMPLE_DIV   = 1000,
    parameter int DB_LEN       = 4,
    parameter int HOLD_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter int N_BTN        = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [1:0]       evt_id,
    output logic             evt_repeat,
    output logic [N_BTN-1:0] btn_level
);

    localparam int ID_W = 2;
    localparam int TW   = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int HW   = $clog2(HOLD_TICKS + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    logic [N_BTN-1:0]  sync1_q, sync2_q;
    logic [TW-1:0]     div_q, div_d;
    logic              tick;
    logic [DB_LEN-1:0] hist_q [N_BTN];
    logic [DB_LEN-1:0] hist_d [N_BTN];
    logic [HW-1:0]     hold_q [N_BTN];
    logic [HW-1:0]     hold_d [N_BTN];
    logic [HW-1:0]     hold_inc;
    logic [N_BTN-1:0]  level_q, level_d, level_prev_q;
    logic [N_BTN-1:0]  pend_q, pend_d, rep_q, rep_d;
    logic [N_BTN-1:0]  set_evt, set_rep, clr_evt;
    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d, id_q, id_d, cand, pick;
    logic              repeat_q, repeat_d, found;

    assign tick  = (div_q == TW'(SAMPLE_DIV - 1));
    assign div_d = tick ? '0 : div_q + 1'b1;

    // Debounce with hysteresis, press detection and hold/auto-repeat timing.
    always_comb begin
        hold_inc = '0;
        for (int i = 0; i < N_BTN; i++) begin
            hist_d[i]  = hist_q[i];
            level_d[i] = level_q[i];
            hold_d[i]  = hold_q[i];
            set_evt[i] = 1'b0;
            set_rep[i] = 1'b0;
            if (tick) begin
                hist_d[i] = {hist_q[i][DB_LEN-2:0], sync2_q[i]};
                if (&hist_d[i]) begin
                    level_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    level_d[i] = 1'b0;
                end
            end
            if (level_q[i] && !level_prev_q[i]) begin
                set_evt[i] = 1'b1;
                set_rep[i] = 1'b0;
                hold_d[i]  = '0;
            end else if (!level_q[i]) begin
                hold_d[i] = '0;
            end else if (tick) begin
                hold_inc = hold_q[i] + 1'b1;
                if (hold_inc == HW'(HOLD_TICKS)) begin
                    set_evt[i] = 1'b1;
                    set_rep[i] = 1'b1;
                    hold_d[i]  = HW'(HOLD_TICKS - REPEAT_TICKS);
                end else begin
                    hold_d[i] = hold_inc;
                end
            end
        end
    end

    // Round-robin search starting at ptr, then the two-state offer FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        repeat_d = repeat_q;
        clr_evt  = '0;
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        for (int k = 0; k < N_BTN; k++) begin
            cand = ptr_q + ID_W'(k);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    id_d          = pick;
                    repeat_d      = rep_q[pick];
                    clr_evt[pick] = 1'b1;
                    state_d       = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    ptr_d   = id_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A set in the same cycle as the grant-clear keeps the bit pending.
        pend_d = (pend_q & ~clr_evt) | set_evt;
        rep_d  = (rep_q & ~set_evt) | (set_evt & set_rep);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            div_q        <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            pend_q       <= '0;
            rep_q        <= '0;
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            repeat_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                hist_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            sync1_q      <= btn_in;
            sync2_q      <= sync1_q;
            div_q        <= div_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            pend_q       <= pend_d;
            rep_q        <= rep_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            repeat_q     <= repeat_d;
            for (int i = 0; i < N_BTN; i++) begin
                hist_q[i] <= hist_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign evt_valid  = (state_q == ST_OFFER);
    assign evt_id     = id_q;
    assign evt_repeat = repeat_q;
    assign btn_level  = level_q;

endmodule
